// File: rtl/iob_axi_ram_responder_if.sv
// AXI4 bus bundle between an AXI master (e.g. the DMA) and iob_axi_ram_responder.
// Signal names carry the responder-side direction suffix.
interface iob_axi_ram_responder_if #(
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ID_W   = 1
);
    logic [AXI_ID_W-1:0]     axi_awid_i;
    logic [AXI_ADDR_W-1:0]   axi_awaddr_i;
    logic [AXI_LEN_W-1:0]    axi_awlen_i;
    logic [2:0]              axi_awsize_i;
    logic [1:0]              axi_awburst_i;
    logic [1:0]              axi_awlock_i;
    logic [3:0]              axi_awcache_i;
    logic [2:0]              axi_awprot_i;
    logic [3:0]              axi_awqos_i;
    logic                    axi_awvalid_i;
    logic                    axi_awready_o;
    logic [AXI_DATA_W-1:0]   axi_wdata_i;
    logic [AXI_DATA_W/8-1:0] axi_wstrb_i;
    logic                    axi_wlast_i;
    logic                    axi_wvalid_i;
    logic                    axi_wready_o;
    logic [AXI_ID_W-1:0]     axi_bid_o;
    logic [1:0]              axi_bresp_o;
    logic                    axi_bvalid_o;
    logic                    axi_bready_i;
    logic [AXI_ID_W-1:0]     axi_arid_i;
    logic [AXI_ADDR_W-1:0]   axi_araddr_i;
    logic [AXI_LEN_W-1:0]    axi_arlen_i;
    logic [2:0]              axi_arsize_i;
    logic [1:0]              axi_arburst_i;
    logic [1:0]              axi_arlock_i;
    logic [3:0]              axi_arcache_i;
    logic [2:0]              axi_arprot_i;
    logic [3:0]              axi_arqos_i;
    logic                    axi_arvalid_i;
    logic                    axi_arready_o;
    logic [AXI_ID_W-1:0]     axi_rid_o;
    logic [AXI_DATA_W-1:0]   axi_rdata_o;
    logic [1:0]              axi_rresp_o;
    logic                    axi_rlast_o;
    logic                    axi_rvalid_o;
    logic                    axi_rready_i;

    modport slave (
        input  axi_awid_i, axi_awaddr_i, axi_awlen_i, axi_awsize_i, axi_awburst_i,
               axi_awlock_i, axi_awcache_i, axi_awprot_i, axi_awqos_i, axi_awvalid_i,
               axi_wdata_i, axi_wstrb_i, axi_wlast_i, axi_wvalid_i, axi_bready_i,
               axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arsize_i, axi_arburst_i,
               axi_arlock_i, axi_arcache_i, axi_arprot_i, axi_arqos_i, axi_arvalid_i,
               axi_rready_i,
        output axi_awready_o, axi_wready_o, axi_bid_o, axi_bresp_o, axi_bvalid_o,
               axi_arready_o, axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o, axi_rvalid_o
    );

    modport master (
        output axi_awid_i, axi_awaddr_i, axi_awlen_i, axi_awsize_i, axi_awburst_i,
               axi_awlock_i, axi_awcache_i, axi_awprot_i, axi_awqos_i, axi_awvalid_i,
               axi_wdata_i, axi_wstrb_i, axi_wlast_i, axi_wvalid_i, axi_bready_i,
               axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arsize_i, axi_arburst_i,
               axi_arlock_i, axi_arcache_i, axi_arprot_i, axi_arqos_i, axi_arvalid_i,
               axi_rready_i,
        input  axi_awready_o, axi_wready_o, axi_bid_o, axi_bresp_o, axi_bvalid_o,
               axi_arready_o, axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o, axi_rvalid_o
    );
endinterface

// File: rtl/iob_axi_ram_responder.sv
// AXI4 slave over a byte-enabled word RAM; independent single-outstanding write and read engines.
// Define IOB_AXI_RAM_RESP_ERR_EN to answer beats beyond the RAM with SLVERR instead of aliasing.
module iob_axi_ram_responder #(
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ID_W   = 1,
    parameter int MEM_ADDR_W = 10
) (
    input logic                    clk_i,
    input logic                    arst_n_i,
    input logic                    cke_i,
    iob_axi_ram_responder_if.slave axi
);
    localparam int NB    = AXI_DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
`ifdef IOB_AXI_RAM_RESP_ERR_EN
    // full word address is kept so beats past the RAM end can be detected
    localparam int WA_W = AXI_ADDR_W - OFF_W;
`else
    localparam int WA_W = MEM_ADDR_W;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [AXI_DATA_W-1:0] mem [2**MEM_ADDR_W];

    w_state_t              w_state, w_state_nxt;
    r_state_t              r_state, r_state_nxt;
    logic                  rdy_q;
    logic [AXI_ID_W-1:0]   w_id, r_id;
    logic [WA_W-1:0]       w_addr, r_addr, rd_addr;
    logic [AXI_LEN_W-1:0]  w_len, w_cnt, r_len, r_cnt;
    logic                  w_fixed, r_fixed, w_err, r_err, w_oor, r_oor;
    logic                  awready, wready, bvalid, arready, rvalid, rd_en;
    logic                  aw_fire, w_fire, ar_fire;
    logic [AXI_DATA_W-1:0] rdata;

    assign aw_fire = axi.axi_awvalid_i & awready;
    assign w_fire  = axi.axi_wvalid_i & wready;
    assign ar_fire = axi.axi_arvalid_i & arready;

`ifdef IOB_AXI_RAM_RESP_ERR_EN
    assign w_oor = (w_addr >> MEM_ADDR_W) != '0;
    assign r_oor = (rd_addr >> MEM_ADDR_W) != '0;
`else
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rdy_q   <= 1'b0;
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else if (cke_i) begin
            rdy_q   <= 1'b1;
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = rdy_q;
                if (axi.axi_awvalid_i && rdy_q) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                // wlast is ignored: the beat count alone closes the burst
                wready = 1'b1;
                if (axi.axi_wvalid_i && w_cnt == w_len) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (axi.axi_bready_i) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_nxt = r_state;
        arready     = 1'b0;
        rvalid      = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = axi.axi_araddr_i[OFF_W +: WA_W];
        case (r_state)
            R_IDLE: begin
                arready = rdy_q;
                if (axi.axi_arvalid_i && rdy_q) begin
                    rd_en       = 1'b1;
                    r_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                // next word is fetched only on advance so rdata holds through stalls
                rvalid  = 1'b1;
                rd_addr = r_fixed ? r_addr : r_addr + WA_W'(1);
                if (axi.axi_rready_i) begin
                    if (r_cnt == r_len) r_state_nxt = R_IDLE;
                    else                rd_en       = 1'b1;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_fixed <= 1'b0;
            w_err   <= 1'b0;
        end else if (cke_i) begin
            if (aw_fire) begin
                w_id    <= axi.axi_awid_i;
                w_addr  <= axi.axi_awaddr_i[OFF_W +: WA_W];
                w_len   <= axi.axi_awlen_i;
                w_cnt   <= '0;
                w_fixed <= (axi.axi_awburst_i == 2'b00);
                w_err   <= 1'b0;
            end else if (w_fire) begin
                if (!w_fixed) w_addr <= w_addr + WA_W'(1);
                w_cnt <= w_cnt + AXI_LEN_W'(1);
                w_err <= w_err | w_oor;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_fixed <= 1'b0;
        end else if (cke_i) begin
            if (rd_en) r_addr <= rd_addr;
            if (ar_fire) begin
                r_id    <= axi.axi_arid_i;
                r_len   <= axi.axi_arlen_i;
                r_cnt   <= '0;
                r_fixed <= (axi.axi_arburst_i == 2'b00);
            end else if (rd_en) begin
                r_cnt <= r_cnt + AXI_LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (cke_i && w_fire && !w_oor) begin
            for (int b = 0; b < NB; b++)
                if (axi.axi_wstrb_i[b]) mem[w_addr[MEM_ADDR_W-1:0]][8*b +: 8] <= axi.axi_wdata_i[8*b +: 8];
        end
    end

    // separate read port: a same-cycle write to this word is not seen
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rdata <= '0;
            r_err <= 1'b0;
        end else if (cke_i && rd_en) begin
            rdata <= r_oor ? '0 : mem[rd_addr[MEM_ADDR_W-1:0]];
            r_err <= r_oor;
        end
    end

    assign axi.axi_awready_o = awready;
    assign axi.axi_wready_o  = wready;
    assign axi.axi_bvalid_o  = bvalid;
    assign axi.axi_bid_o     = w_id;
    assign axi.axi_bresp_o   = {w_err, 1'b0};
    assign axi.axi_arready_o = arready;
    assign axi.axi_rvalid_o  = rvalid;
    assign axi.axi_rid_o     = r_id;
    assign axi.axi_rdata_o   = rdata;
    assign axi.axi_rresp_o   = {r_err, 1'b0};
    assign axi.axi_rlast_o   = rvalid & (r_cnt == r_len);

    logic unused_ok;
    assign unused_ok = ^{axi.axi_awsize_i, axi.axi_awlock_i, axi.axi_awcache_i, axi.axi_awprot_i,
                         axi.axi_awqos_i, axi.axi_arsize_i, axi.axi_arlock_i, axi.axi_arcache_i,
                         axi.axi_arprot_i, axi.axi_arqos_i, axi.axi_wlast_i,
                         axi.axi_awaddr_i, axi.axi_araddr_i};
endmodule

// File: tb/tb_iob_axi_ram_responder.sv
// Randomized scoreboard bench for iob_axi_ram_responder against a byte-array memory model.
module tb_iob_axi_ram_responder;
    localparam int AW = 24, DW = 32, LW = 8, IW = 1, MW = 10;
    localparam int RAM_BYTES = (2**MW) * (DW/8);
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } r_exp_t;
    typedef struct {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } b_exp_t;

    logic clk = 1'b0, arst_n = 1'b1, cke = 1'b1;
    always #5 clk = ~clk;

    iob_axi_ram_responder_if #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_LEN_W(LW), .AXI_ID_W(IW)) bus ();

    iob_axi_ram_responder #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_LEN_W(LW), .AXI_ID_W(IW),
                            .MEM_ADDR_W(MW))
        dut (.clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .axi(bus));

    int n_chk = 0, n_fail = 0, r_seen = 0;
    logic [7:0]  ref_mem [RAM_BYTES];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    r_exp_t exp_r [$];
    b_exp_t exp_b [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // byte address of beat i: FIXED stays put, INCR and WRAP step one full word
    function automatic int beat_addr(input int addr, input int i, input logic [1:0] burst);
        int a = addr & ~3;
        if (burst != FIXED) a = a + 4 * i;
        return a & ((1 << AW) - 1);
    endfunction

    function automatic bit is_oor(input int a);
`ifdef IOB_AXI_RAM_RESP_ERR_EN
        return a >= RAM_BYTES;
`else
        return (a < 0);
`endif
    endfunction

    function automatic void push_read_exp(input int id, input int addr, input int len, input logic [1:0] burst);
        r_exp_t e;
        int a;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, i, burst);
            e.id   = id[IW-1:0];
            e.last = (i == len);
            e.data = '0;
            e.resp = 2'b10;
            if (!is_oor(a)) begin
                e.resp = 2'b00;
                for (int b = 0; b < 4; b++) e.data[8*b +: 8] = ref_mem[(a % RAM_BYTES) + b];
            end
            exp_r.push_back(e);
        end
    endfunction

    task automatic do_write(input int id, input int addr, input int len, input logic [1:0] burst,
                            input int bdelay, input bit wgap);
        b_exp_t eb;
        int a, n;
        bit err = 0;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, i, burst);
            if (is_oor(a)) err = 1;
            else for (int b = 0; b < 4; b++)
                if (ws[i][b]) ref_mem[(a % RAM_BYTES) + b] = wd[i][8*b +: 8];
        end
        eb.id = id[IW-1:0];
        eb.resp = err ? 2'b10 : 2'b00;
        exp_b.push_back(eb);
        bus.axi_awid_i = id[IW-1:0];
        bus.axi_awaddr_i = addr[AW-1:0];
        bus.axi_awlen_i = len[LW-1:0];
        bus.axi_awburst_i = burst;
        bus.axi_awsize_i = 3'd2;
        bus.axi_awvalid_i = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.axi_awready_o && n < 100);
        if (!bus.axi_awready_o) fail("aw_timeout");
        @(posedge clk); #1;
        bus.axi_awvalid_i = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (wgap && $urandom_range(0, 3) == 0) begin
                bus.axi_wvalid_i = 1'b0;
                @(posedge clk); #1;
            end
            bus.axi_wvalid_i = 1'b1;
            bus.axi_wdata_i = wd[i];
            bus.axi_wstrb_i = ws[i];
            bus.axi_wlast_i = (i == len);
            n = 0;
            do begin @(negedge clk); n++; chk("aw_busy", bus.axi_awready_o, 0); end
            while (!bus.axi_wready_o && n < 100);
            if (!bus.axi_wready_o) fail("w_timeout");
            @(posedge clk); #1;
        end
        bus.axi_wvalid_i = 1'b0;
        bus.axi_wlast_i = 1'b0;
        bus.axi_bready_i = (bdelay == 0);
        for (int k = 0; k < bdelay; k++) begin
            @(negedge clk);
            chk("bvalid_hold", bus.axi_bvalid_o, 1);
            chk("awready_in_resp", bus.axi_awready_o, 0);
            @(posedge clk); #1;
        end
        bus.axi_bready_i = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.axi_bvalid_o && n < 100);
        if (!bus.axi_bvalid_o) fail("b_timeout");
        @(posedge clk); #1;
        bus.axi_bready_i = 1'b0;
        @(negedge clk);
        chk("bvalid_drop", bus.axi_bvalid_o, 0);
        chk("awready_back", bus.axi_awready_o, 1);
        @(posedge clk); #1;
    endtask

    task automatic send_ar(input int id, input int addr, input int len, input logic [1:0] burst);
        int n = 0;
        bus.axi_arid_i = id[IW-1:0];
        bus.axi_araddr_i = addr[AW-1:0];
        bus.axi_arlen_i = len[LW-1:0];
        bus.axi_arburst_i = burst;
        bus.axi_arsize_i = 3'd2;
        bus.axi_arvalid_i = 1'b1;
        do begin @(negedge clk); n++; end while (!bus.axi_arready_o && n < 100);
        if (!bus.axi_arready_o) fail("ar_timeout");
        @(posedge clk); #1;
        bus.axi_arvalid_i = 1'b0;
    endtask

    // mode 0: rready held high (checks one beat per cycle); mode 1: random rready
    task automatic do_read(input int id, input int addr, input int len, input logic [1:0] burst, input int mode);
        int start, cyc;
        push_read_exp(id, addr, len, burst);
        send_ar(id, addr, len, burst);
        start = r_seen;
        cyc = 0;
        while ((r_seen - start) < len + 1 && cyc < 4000) begin
            bus.axi_rready_i = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        bus.axi_rready_i = 1'b0;
        chk("r_beats", r_seen - start, len + 1);
        if (mode == 0) chk("r_cycles", cyc, len + 1);
        repeat (2) begin @(negedge clk); chk("r_idle", bus.axi_rvalid_o, 0); end
        @(posedge clk); #1;
        chk("r_queue_empty", exp_r.size(), 0);
    endtask

    always @(negedge clk) begin
        if (arst_n) begin
            if (bus.axi_bvalid_o && bus.axi_bready_i) begin
                if (exp_b.size() == 0) fail("b_unexpected");
                else begin
                    chk("bid", bus.axi_bid_o, exp_b[0].id);
                    chk("bresp", bus.axi_bresp_o, exp_b[0].resp);
                    exp_b.delete(0);
                end
            end
            if (bus.axi_rvalid_o) begin
                if (exp_r.size() == 0) fail("r_unexpected");
                else begin
                    // compared every valid cycle, so stalled beats must hold their data
                    chk("rid", bus.axi_rid_o, exp_r[0].id);
                    chk("rdata", bus.axi_rdata_o, exp_r[0].data);
                    chk("rresp", bus.axi_rresp_o, exp_r[0].resp);
                    chk("rlast", bus.axi_rlast_o, exp_r[0].last);
                    if (bus.axi_rready_i) begin
                        exp_r.delete(0);
                        r_seen++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.axi_awid_i = '0;  bus.axi_awaddr_i = '0; bus.axi_awlen_i = '0;  bus.axi_awsize_i = '0;
        bus.axi_awburst_i = '0; bus.axi_awlock_i = '0; bus.axi_awcache_i = '0; bus.axi_awprot_i = '0;
        bus.axi_awqos_i = '0; bus.axi_awvalid_i = 1'b0; bus.axi_wdata_i = '0; bus.axi_wstrb_i = '0;
        bus.axi_wlast_i = 1'b0; bus.axi_wvalid_i = 1'b0; bus.axi_bready_i = 1'b0;
        bus.axi_arid_i = '0;  bus.axi_araddr_i = '0; bus.axi_arlen_i = '0;  bus.axi_arsize_i = '0;
        bus.axi_arburst_i = '0; bus.axi_arlock_i = '0; bus.axi_arcache_i = '0; bus.axi_arprot_i = '0;
        bus.axi_arqos_i = '0; bus.axi_arvalid_i = 1'b0; bus.axi_rready_i = 1'b0;
        for (int i = 0; i < RAM_BYTES; i++) ref_mem[i] = 8'h00;
        #1 arst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", bus.axi_awready_o, 0);
        chk("rst_wready", bus.axi_wready_o, 0);
        chk("rst_bvalid", bus.axi_bvalid_o, 0);
        chk("rst_bid", bus.axi_bid_o, 0);
        chk("rst_bresp", bus.axi_bresp_o, 0);
        chk("rst_arready", bus.axi_arready_o, 0);
        chk("rst_rvalid", bus.axi_rvalid_o, 0);
        chk("rst_rlast", bus.axi_rlast_o, 0);
        chk("rst_rid", bus.axi_rid_o, 0);
        chk("rst_rresp", bus.axi_rresp_o, 0);
        chk("rst_rdata", bus.axi_rdata_o, 0);
        arst_n = 1'b1;
        #1 chk("awready_pre_flag", bus.axi_awready_o, 0);
        @(posedge clk); #1;
        chk("awready_post_flag", bus.axi_awready_o, 1);
        chk("arready_post_flag", bus.axi_arready_o, 1);

        // single beat
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(1, 'h10, 0, INCR, 0, 0);
        do_read(1, 'h10, 0, INCR, 0);

        // 16-beat INCR, full-rate and randomly stalled reads
        for (int i = 0; i < 16; i++) begin wd[i] = i; ws[i] = 4'hF; end
        do_write(0, 'h100, 15, INCR, 0, 0);
        do_read(0, 'h100, 15, INCR, 0);
        do_read(1, 'h100, 15, INCR, 1);

        // partial strobe overwrite
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        do_write(0, 'h40, 0, INCR, 1, 0);
        wd[0] = 32'hDEADBEEF; ws[0] = 4'h3;
        do_write(1, 'h40, 0, INCR, 0, 0);
        do_read(0, 'h40, 0, INCR, 0);

        // concurrent write with stalled B and full-rate read elsewhere
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        fork
            do_write(1, 'h200, 7, INCR, 5, 0);
            do_read(0, 'h100, 7, INCR, 0);
        join
        do_read(1, 'h200, 7, WRAP, 0);

        // FIXED burst: later beats land on the same word
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        ws[3] = 4'h5;
        do_write(0, 'h300, 3, FIXED, 0, 1);
        do_read(0, 'h300, 2, FIXED, 1);

        // maximum length burst fills 0x400..0x7FF
        for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(0, 'h400, 255, INCR, 0, 0);
        do_read(1, 'h400, 255, INCR, 0);

        for (int it = 0; it < 12; it++) begin
            int a, l;
            logic [1:0] bu;
            a = 'h400 + 4 * $urandom_range(0, 200);
            l = $urandom_range(0, 15);
            bu = 2'($urandom_range(0, 2));
            for (int i = 0; i <= l; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(1, 15)); end
            do_write($urandom_range(0, 1), a, l, bu, $urandom_range(0, 3), 1);
            do_read($urandom_range(0, 1), a, l, bu, $urandom_range(0, 1));
        end

        // reset in the middle of an 8-beat read
        push_read_exp(0, 'h100, 7, INCR);
        send_ar(0, 'h100, 7, INCR);
        bus.axi_rready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 arst_n = 1'b0;
        #1;
        chk("midrst_rvalid", bus.axi_rvalid_o, 0);
        chk("midrst_arready", bus.axi_arready_o, 0);
        chk("midrst_rlast", bus.axi_rlast_o, 0);
        exp_r.delete();
        bus.axi_rready_i = 1'b0;
        @(posedge clk); #1;
        arst_n = 1'b1;
        #1 chk("arready_pre_rel", bus.axi_arready_o, 0);
        @(posedge clk); #1;
        chk("arready_post_rel", bus.axi_arready_o, 1);
        do_read(1, 'h100, 7, INCR, 0);

        // top-of-RAM wrap, then an address just past the RAM
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(1, 'hFF8, 3, INCR, 0, 0);
        do_read(0, 'hFF8, 3, INCR, 0);
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
        do_write(0, 'h1000, 0, INCR, 0, 0);
        do_read(1, 'h1000, 0, INCR, 1);

        chk("b_queue_empty", exp_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/iob_axi_ram_responder.md
Name: iob_axi_ram_responder

Overview:
- AXI4 full slave (responder) backed by an internal word-addressed RAM.
- It is the other end of the DMA's AXI master port: it serves the INCR bursts the DMA issues for stream-to-memory and memory-to-stream transfers.
- Used as on-chip scratch memory and as the memory model in DMA system benches.
- Independent write and read engines, each with one outstanding transaction.

Parameters:
AXI_ADDR_W, 24, byte address width
AXI_DATA_W, 32, data width; power of 2, >= 8
AXI_LEN_W, 8, burst length field width
AXI_ID_W, 1, ID width
MEM_ADDR_W, 10, log2 of RAM depth in AXI_DATA_W words

Ports:
- clk_i  in  1  clock.
- arst_n_i  in  1  reset, active-low.
- cke_i  in  1  clock enable; when 0, all state frozen.
- Write address channel:
  - axi_awid_i, axi_awaddr_i, axi_awlen_i, axi_awsize_i(3), axi_awburst_i(2), axi_awvalid_i  in  write address channel.
  - axi_awready_o  out  1.
- Write data channel:
  - axi_wdata_i, axi_wstrb_i(AXI_DATA_W/8), axi_wlast_i, axi_wvalid_i  in.
  - axi_wready_o  out  1.
- Write response channel:
  - axi_bid_o  out  AXI_ID_W.
  - axi_bresp_o  out  2.
  - axi_bvalid_o  out  1.
  - axi_bready_i  in  1.
- Read address channel:
  - axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arsize_i, axi_arburst_i, axi_arvalid_i  in.
  - axi_arready_o  out  1.
- Read data channel:
  - axi_rid_o  out  AXI_ID_W.
  - axi_rdata_o  out  AXI_DATA_W.
  - axi_rresp_o  out  2.
  - axi_rlast_o  out  1.
  - axi_rvalid_o  out  1.
  - axi_rready_i  in  1.
- axi_{aw,ar}{lock,cache,prot,qos}_i  in  2/4/3/4  accepted and ignored.

Behaviour:
- Clock and reset: one clock, clk_i. Reset arst_n_i is asynchronous, active-low.
- Reset values:
  - All *valid_o, *ready_o, axi_rlast_o = 0.
  - bid/rid/bresp/rresp/rdata = 0.
  - RAM contents are not reset.
  - A ready flag sets 1 cycle after arst_n_i deasserts; axi_awready_o/axi_arready_o stay 0 until then.
- Address conversion:
  - Word address = byte address >> log2(AXI_DATA_W/8).
  - Low MEM_ADDR_W bits index the RAM.
- Burst types and sizes:
  - INCR: word address +1 per beat.
  - FIXED: no increment.
  - WRAP: treated as INCR.
  - axsize is ignored; all beats are full width.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On AW handshake, capture id, word address and len, clear beat count, go to W_DATA. awready drops the next cycle.
  - W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb to RAM[addr], then increments addr and count. On the beat where count==len, go to W_RESP.
  - wlast is not checked; beat count alone ends the burst.
  - W_RESP: bvalid=1, bid=captured id, bresp=OKAY(00). Hold until bready; then go to W_IDLE.
  - No new AW is accepted until the B handshake.
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On AR handshake, capture id, address and len; issue RAM read of the first word; go to R_DATA.
  - The synchronous RAM read makes rvalid rise 1 cycle after the AR handshake.
  - R_DATA: rvalid=1, rid=captured id, rresp=OKAY, rlast=(count==len).
  - On R handshake, if not last: issue the next-address read in the same cycle, so throughput is 1 beat/cycle with rready high. If last: go to R_IDLE.
  - RAM read enable is asserted only on advance, so rdata holds stable while rvalid & ~rready.
- Concurrency:
  - Read and write engines run concurrently on separate RAM ports.
  - Same-cycle same-address read and write: read returns the old data.
- Width rules:
  - Beat counter is AXI_LEN_W bits; burst length is len+1, so a maximum of 256 beats.
  - The word address wraps modulo 2**MEM_ADDR_W.
- Reset mid-burst: both FSMs return to idle and the burst is abandoned. Beats already written remain in RAM.

Optional Feature:
- Macro: IOB_AXI_RAM_RESP_ERR_EN.
- Defined:
  - A beat whose byte address is >= 2**MEM_ADDR_W*(AXI_DATA_W/8), with AXI_ADDR_W bits evaluated, is out of range.
  - Out-of-range write beat: suppressed, and the whole burst returns bresp=SLVERR(10).
  - Out-of-range read beat: rdata=0, rresp=SLVERR, for that beat only.
  - Handshake timing is unchanged.
- Undefined: the address is taken modulo the RAM size and responses are always OKAY.

Test Plan:
- Write awaddr=0x10 len=0 wdata=0xDEADBEEF wstrb=0xF id=1 -> bvalid, bid=1, bresp=00. Read araddr=0x10 len=0 -> rdata=0xDEADBEEF, rlast=1, rid matches.
- 16-beat INCR write at 0x100 with data 0..15, then 16-beat read with rready=1 -> 16 consecutive rvalid cycles starting 1 cycle after AR, data 0..15, rlast only on beat 16.
- Read of the same 16 beats with rready toggling pseudo-randomly -> rdata stable during stalls; exactly 16 beats, no duplicates or drops.
- Write 0x11223344, then rewrite with wstrb=0x3 and data 0xDEADBEEF -> read returns 0x1122BEEF.
- Concurrent 8-beat write at 0x200 and 8-beat read at 0x100, bready held low 5 cycles -> bvalid held 5 cycles, awready=0 until B handshake; read data correct and unaffected.
- Assert arst_n_i low mid 8-beat read -> rvalid drops immediately; arready=1 one cycle after release; new read succeeds. With macro defined: read at 0x1000 (4 KiB, MEM_ADDR_W=10) -> rresp=10, rdata=0.
